// File: rtl/idu_decode_stage_if.sv
// Fetch-side, execute-side and write-back signals of the decode stage.
// master drives fetch/EXU-ready/write-back; slave is the decode stage itself.
interface idu_decode_stage_if;
  logic        ifu_valid;
  logic        ifu_ready;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_inst;
  logic        flush;
  logic        exu_valid;
  logic        exu_ready;
  logic [31:0] exu_pc;
  logic [31:0] exu_inst;
  logic [4:0]  exu_rs1;
  logic [4:0]  exu_rs2;
  logic [4:0]  exu_rd;
  logic [31:0] exu_imm;
  logic [3:0]  exu_opclass;
  logic        exu_wen;
  logic        exu_fencei;
  logic [63:0] exu_seq;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  modport master (
    output ifu_valid, ifu_pc, ifu_inst, flush, exu_ready, wb_valid, wb_rd,
    input  ifu_ready, exu_valid, exu_pc, exu_inst, exu_rs1, exu_rs2, exu_rd,
           exu_imm, exu_opclass, exu_wen, exu_fencei, exu_seq
  );

  modport slave (
    input  ifu_valid, ifu_pc, ifu_inst, flush, exu_ready, wb_valid, wb_rd,
    output ifu_ready, exu_valid, exu_pc, exu_inst, exu_rs1, exu_rs2, exu_rd,
           exu_imm, exu_opclass, exu_wen, exu_fencei, exu_seq
  );
endinterface

// File: rtl/idu_decode_stage.sv
// RV32I decode stage: single-entry holding register, combinational decode and
// a per-register pending-write scoreboard that blocks RAW hazards.
//
// state | meaning
// EMPTY | valid_q=0, nothing held, fetch always accepted
// FULL  | valid_q=1, instruction held until issued or flushed
module idu_decode_stage #(
  parameter int          SB_CNT_W = 2,
  parameter logic [63:0] SEQ_INIT = 64'h1
) (
  input logic             clock,
  input logic             reset,
  idu_decode_stage_if.slave bus
);
  localparam logic [3:0] OC_ALU = 4'd0, OC_ALUI = 4'd1, OC_LOAD = 4'd2, OC_STORE = 4'd3,
                         OC_BRANCH = 4'd4, OC_JAL = 4'd5, OC_JALR = 4'd6, OC_LUI = 4'd7,
                         OC_AUIPC = 4'd8, OC_SYSTEM = 4'd9, OC_FENCE = 4'd10, OC_ILLEGAL = 4'd15;
  localparam logic [SB_CNT_W-1:0] CNT_FULL = {SB_CNT_W{1'b1}};

  logic                valid_q, valid_d;
  logic [31:0]         pc_q, inst_q;
  logic [63:0]         seq_q, seq_cnt_q;
  logic [SB_CNT_W-1:0] cnt_q [32];
  logic [SB_CNT_W-1:0] cnt_d [32];

  logic        accept, issue, raw_stall;
  logic [3:0]  cls;
  logic [31:0] imm;
  logic        writes, rs1_used, rs2_used, wen;
  logic [4:0]  rs1, rs2, rd;

  assign rs1 = inst_q[19:15];
  assign rs2 = inst_q[24:20];
  assign rd  = inst_q[11:7];

  // state register and payload
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      seq_q     <= '0;
      seq_cnt_q <= SEQ_INIT;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        pc_q      <= bus.ifu_pc;
        inst_q    <= bus.ifu_inst;
        seq_q     <= seq_cnt_q;
        seq_cnt_q <= seq_cnt_q + 64'd1;
      end
    end
  end

  // next state; flush wins over both accept and issue
  always_comb begin
    valid_d = valid_q;
    if (bus.flush)   valid_d = 1'b0;
    else if (accept) valid_d = 1'b1;
    else if (issue)  valid_d = 1'b0;
  end

  always_comb begin
    cls      = OC_ILLEGAL;
    imm      = '0;
    writes   = 1'b0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    if (inst_q[1:0] == 2'b11) begin
      case (inst_q[6:0])
        7'b0110011: begin cls = OC_ALU;    writes = 1'b1; rs2_used = 1'b1; end
        7'b0010011: begin cls = OC_ALUI;   writes = 1'b1; imm = {{20{inst_q[31]}}, inst_q[31:20]}; end
        7'b0000011: begin cls = OC_LOAD;   writes = 1'b1; imm = {{20{inst_q[31]}}, inst_q[31:20]}; end
        7'b0100011: begin
          cls = OC_STORE; rs2_used = 1'b1;
          imm = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
        end
        7'b1100011: begin
          cls = OC_BRANCH; rs2_used = 1'b1;
          imm = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
        end
        7'b1101111: begin
          cls = OC_JAL; writes = 1'b1; rs1_used = 1'b0;
          imm = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
        end
        7'b1100111: begin cls = OC_JALR;  writes = 1'b1; imm = {{20{inst_q[31]}}, inst_q[31:20]}; end
        7'b0110111: begin cls = OC_LUI;   writes = 1'b1; rs1_used = 1'b0; imm = {inst_q[31:12], 12'h000}; end
        7'b0010111: begin cls = OC_AUIPC; writes = 1'b1; rs1_used = 1'b0; imm = {inst_q[31:12], 12'h000}; end
        // only CSR forms (funct3 != 0) write rd; ecall/ebreak do not
        7'b1110011: begin cls = OC_SYSTEM; writes = (inst_q[14:12] != 3'b000); imm = {{20{inst_q[31]}}, inst_q[31:20]}; end
        7'b0001111: begin cls = OC_FENCE;  imm = {{20{inst_q[31]}}, inst_q[31:20]}; end
        default:    cls = OC_ILLEGAL;
      endcase
    end
  end

  assign wen       = writes & (rd != 5'd0);
  assign raw_stall = (rs1_used & (rs1 != 5'd0) & (cnt_q[rs1] != '0))
                   | (rs2_used & (rs2 != 5'd0) & (cnt_q[rs2] != '0))
                   | (wen & (cnt_q[rd] == CNT_FULL));

  // outputs
  always_comb begin
    bus.exu_valid = valid_q & ~raw_stall & ~bus.flush;
    bus.ifu_ready = ~valid_q | (bus.exu_valid & bus.exu_ready);
    issue         = bus.exu_valid & bus.exu_ready;
    accept        = bus.ifu_valid & bus.ifu_ready & ~bus.flush;
  end

  assign bus.exu_pc      = pc_q;
  assign bus.exu_inst    = inst_q;
  assign bus.exu_rs1     = rs1;
  assign bus.exu_rs2     = rs2;
  assign bus.exu_rd      = rd;
  assign bus.exu_imm     = imm;
  assign bus.exu_opclass = valid_q ? cls : 4'd0;
  assign bus.exu_wen     = wen;
  assign bus.exu_fencei  = (inst_q == 32'h0000100F);
  assign bus.exu_seq     = seq_q;

  // scoreboard: simultaneous issue and retire to the same rd cancel out
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        if (issue & wen & (rd == 5'(r))) begin
          if (!(bus.wb_valid & (bus.wb_rd == 5'(r))))
            cnt_d[r] = cnt_q[r] + 1'b1;
        end else if (bus.wb_valid & (bus.wb_rd == 5'(r)) & (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end else begin
        cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end
endmodule

// File: tb/tb_idu_decode_stage.sv
// Directed bench for idu_decode_stage: handshake, RAW stalls, flush,
// scoreboard saturation, immediate decode and asynchronous reset.
module tb_idu_decode_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  idu_decode_stage_if bus ();

  idu_decode_stage #(.SB_CNT_W(2), .SEQ_INIT(64'h1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ifu(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    bus.ifu_valid = v;
    bus.ifu_pc    = pc;
    bus.ifu_inst  = inst;
  endtask

  logic [31:0] sw_inst [6];
  logic [3:0]  sw_cls  [6];
  logic [31:0] sw_imm  [6];
  logic        sw_wen  [6];
  logic        sw_fi   [6];

  initial begin
    sw_inst[0] = 32'hFE000EE3; sw_cls[0] = 4'd4;  sw_imm[0] = 32'hFFFFFFFC; sw_wen[0] = 1'b0; sw_fi[0] = 1'b0;
    sw_inst[1] = 32'h123453B7; sw_cls[1] = 4'd7;  sw_imm[1] = 32'h12345000; sw_wen[1] = 1'b1; sw_fi[1] = 1'b0;
    sw_inst[2] = 32'h0000100F; sw_cls[2] = 4'd10; sw_imm[2] = 32'h00000000; sw_wen[2] = 1'b0; sw_fi[2] = 1'b1;
    sw_inst[3] = 32'hFFFFFFFF; sw_cls[3] = 4'd15; sw_imm[3] = 32'h00000000; sw_wen[3] = 1'b0; sw_fi[3] = 1'b0;
    sw_inst[4] = 32'hFE002C23; sw_cls[4] = 4'd3;  sw_imm[4] = 32'hFFFFFFF8; sw_wen[4] = 1'b0; sw_fi[4] = 1'b0;
    sw_inst[5] = 32'h008000EF; sw_cls[5] = 4'd5;  sw_imm[5] = 32'h00000008; sw_wen[5] = 1'b1; sw_fi[5] = 1'b0;

    drive_ifu(1'b0, 32'h0, 32'h0);
    bus.flush     = 1'b0;
    bus.exu_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid",   bus.exu_valid, 1'b0);
    chk("rst_ready",   bus.ifu_ready, 1'b1);
    chk("rst_pc",      bus.exu_pc, 32'h0);
    chk("rst_imm",     bus.exu_imm, 32'h0);
    chk("rst_opclass", bus.exu_opclass, 4'd0);
    chk("rst_seq",     bus.exu_seq, 64'h0);
    reset = 1'b0;

    // addi x1,x0,5 then add x2,x1,x1 back-to-back
    drive_ifu(1'b1, 32'h30000000, 32'h00500093);
    bus.exu_ready = 1'b1;
    #1 chk("t1_ifu_ready", bus.ifu_ready, 1'b1);
    tick();
    drive_ifu(1'b1, 32'h30000004, 32'h00108133);
    #1;
    chk("t1_valid",   bus.exu_valid, 1'b1);
    chk("t1_opclass", bus.exu_opclass, 4'd1);
    chk("t1_rd",      bus.exu_rd, 5'd1);
    chk("t1_imm",     bus.exu_imm, 32'd5);
    chk("t1_wen",     bus.exu_wen, 1'b1);
    chk("t1_seq",     bus.exu_seq, 64'd1);
    chk("t1_pc",      bus.exu_pc, 32'h30000000);
    tick();
    bus.ifu_valid = 1'b0;
    #1;
    chk("t2_stall_valid", bus.exu_valid, 1'b0);
    chk("t2_stall_ready", bus.ifu_ready, 1'b0);
    chk("t2_seq",         bus.exu_seq, 64'd2);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    #1 chk("t2_wb_cycle_valid", bus.exu_valid, 1'b0);
    tick();
    bus.wb_valid  = 1'b0;
    bus.exu_ready = 1'b0;
    #1;
    chk("t2_issue_valid", bus.exu_valid, 1'b1);
    chk("t2_issue_rd",    bus.exu_rd, 5'd2);
    chk("t2_issue_cls",   bus.exu_opclass, 4'd0);

    // EXU backpressure for three cycles
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", bus.exu_valid, 1'b1);
      chk("t3_hold_pc",    bus.exu_pc, 32'h30000004);
      chk("t3_hold_ready", bus.ifu_ready, 1'b0);
      tick();
    end
    bus.exu_ready = 1'b1;
    #1 chk("t3_release_ready", bus.ifu_ready, 1'b1);
    tick();
    #1 chk("t3_single_issue", bus.exu_valid, 1'b0);

    // flush while FULL with a new fetch offered
    drive_ifu(1'b1, 32'h30000010, 32'h00700193);
    bus.exu_ready = 1'b0;
    tick();
    drive_ifu(1'b1, 32'h30000014, 32'h00100213);
    bus.flush = 1'b1;
    #1;
    chk("t4_flush_valid", bus.exu_valid, 1'b0);
    chk("t4_flush_ready", bus.ifu_ready, 1'b0);
    tick();
    bus.flush     = 1'b0;
    bus.ifu_valid = 1'b0;
    bus.exu_ready = 1'b1;
    #1;
    chk("t4_empty_valid", bus.exu_valid, 1'b0);
    chk("t4_empty_ready", bus.ifu_ready, 1'b1);
    drive_ifu(1'b1, 32'h30000018, 32'h00018333);
    tick();
    bus.ifu_valid = 1'b0;
    #1;
    chk("t4_x3_not_pending", bus.exu_valid, 1'b1);
    chk("t4_seq_no_rewind",  bus.exu_seq, 64'd3 + 64'd1);
    drive_ifu(1'b1, 32'h3000001C, 32'h00010433);
    tick();
    bus.ifu_valid = 1'b0;
    #1 chk("t4_x2_pending", bus.exu_valid, 1'b0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd2;
    tick();
    bus.wb_valid = 1'b0;
    #1 chk("t4_x2_retired", bus.exu_valid, 1'b1);
    tick();

    // four writers to x5: three fit in a 2-bit counter, the fourth waits
    drive_ifu(1'b1, 32'h30000020, 32'h00100293);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1 chk("t5_writer_issue", bus.exu_valid, 1'b1);
      tick();
    end
    bus.ifu_valid = 1'b0;
    #1;
    chk("t5_sat_valid", bus.exu_valid, 1'b0);
    chk("t5_sat_ready", bus.ifu_ready, 1'b0);
    tick();
    #1 chk("t5_sat_hold", bus.exu_valid, 1'b0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    tick();
    bus.wb_valid = 1'b0;
    #1 chk("t5_after_wb", bus.exu_valid, 1'b1);
    tick();

    // decode sweep
    for (int v = 0; v < 6; v++) begin
      drive_ifu(1'b1, 32'h30000100 + 32'(v * 4), sw_inst[v]);
      tick();
      bus.ifu_valid = 1'b0;
      #1;
      chk("t6_valid",   bus.exu_valid, 1'b1);
      chk("t6_opclass", bus.exu_opclass, sw_cls[v]);
      chk("t6_imm",     bus.exu_imm, sw_imm[v]);
      chk("t6_wen",     bus.exu_wen, sw_wen[v]);
      chk("t6_fencei",  bus.exu_fencei, sw_fi[v]);
      tick();
    end

    // asynchronous reset while FULL; x5 counter (saturated) must be cleared
    drive_ifu(1'b1, 32'h30000200, 32'h00100293);
    bus.exu_ready = 1'b0;
    tick();
    bus.ifu_valid = 1'b0;
    #1 chk("t7_pre_rst_stalled", bus.exu_valid, 1'b0);
    reset = 1'b1;
    #1;
    chk("t7_rst_valid", bus.exu_valid, 1'b0);
    chk("t7_rst_inst",  bus.exu_inst, 32'h0);
    chk("t7_rst_ready", bus.ifu_ready, 1'b1);
    reset = 1'b0;
    drive_ifu(1'b1, 32'h30000204, 32'h00100293);
    tick();
    bus.ifu_valid = 1'b0;
    #1;
    chk("t7_cnt_cleared", bus.exu_valid, 1'b1);
    chk("t7_seq_restart", bus.exu_seq, 64'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
